// File: rtl/cpu_pipe_pkg.sv
// Types shared by the MEM and WB stages: the MEM FSM states, the register-address
// width, the reset value and the WB control bundle.
package cpu_pipe_pkg;

  localparam int          REG_ADDR_W = 5;
  localparam logic [31:0] RST_VAL    = 32'h0;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_REQ  = 2'd1,
    MS_WAIT = 2'd2,
    MS_DONE = 2'd3
  } ms_state_e;

  typedef struct packed {
    logic                  valid;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rd;
    logic [31:0]           pc;
  } ws_bundle_t;

endpackage

// File: rtl/mem_watchdog.sv
// Counts consecutive WAIT cycles and raises a sticky error when the count reaches
// TIMEOUT_CYC; the error only clears on reset.
module mem_watchdog #(
  parameter int TIMEOUT_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_wait,
  output logic o_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // Counter saturates at TIMEOUT_CYC so the error edge is seen exactly once per stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (!i_wait) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_W'(TIMEOUT_CYC)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (i_wait && (r_cnt == CNT_W'(TIMEOUT_CYC - 1))) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_err = r_err;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: runs data-SRAM request/response transactions and builds the WB bundle.
// Define MS_FWD_EN to add the MEM->EXE forwarding outputs.
module mem_stage_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ms_valid,
  input  logic [DATA_W-1:0]     mem_alu_result,
  input  logic                  mem_ref_we,
  input  logic                  mem_dram_re,
  input  logic                  mem_dram_we,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_res_from_dram,
  input  logic [ADDR_W-1:0]     mem_dram_waddr,
  input  logic [DATA_W-1:0]     mem_dram_wdata,
  input  logic [31:0]           mem_pc,
  output logic                  ms_ready_go,
  output logic                  data_sram_req,
  output logic                  data_sram_wr,
  output logic [ADDR_W-1:0]     data_sram_addr,
  output logic [DATA_W-1:0]     data_sram_wdata,
  input  logic                  data_sram_addr_ok,
  input  logic                  data_sram_data_ok,
  input  logic [DATA_W-1:0]     data_sram_rdata,
  input  logic                  ws_allowin,
  output logic                  ms_to_ws_valid,
  output logic                  ws_rf_we,
  output logic [REG_ADDR_W-1:0] ws_rd,
  output logic [DATA_W-1:0]     ws_wdata,
  output logic [31:0]           ws_pc,
`ifdef MS_FWD_EN
  output logic                  ms_fwd_valid,
  output logic [REG_ADDR_W-1:0] ms_fwd_rd,
  output logic [DATA_W-1:0]     ms_fwd_data,
  output logic                  ms_fwd_block,
`endif
  output logic                  mem_err
);

  ms_state_e         r_state;
  logic [DATA_W-1:0] r_rdata;

  logic              w_mem_op;
  logic              w_rsp_take;
  logic              w_alu_retire;
  logic              w_wb_valid;
  logic              w_err;
  logic [DATA_W-1:0] w_wdata_mux;
  ws_bundle_t        w_wb;

  assign w_mem_op = mem_dram_re | mem_dram_we;

  // A response is only meaningful once the request has been accepted.
  assign w_rsp_take = ((r_state == MS_REQ) && data_sram_addr_ok && data_sram_data_ok) ||
                      ((r_state == MS_WAIT) && data_sram_data_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MS_IDLE;
      r_rdata <= DATA_W'(RST_VAL);
    end else begin
      if (w_rsp_take && mem_dram_re) begin
        r_rdata <= data_sram_rdata;
      end
      case (r_state)
        MS_IDLE: if (ms_valid && w_mem_op) r_state <= MS_REQ;
        MS_REQ:  if (data_sram_addr_ok) r_state <= data_sram_data_ok ? MS_DONE : MS_WAIT;
        MS_WAIT: if (data_sram_data_ok) r_state <= MS_DONE;
        MS_DONE: if (ws_allowin) r_state <= MS_IDLE;
        default: r_state <= MS_IDLE;
      endcase
    end
  end

  // Non-memory ops retire straight out of IDLE with no added latency.
  assign w_alu_retire = (r_state == MS_IDLE) && ms_valid && !w_mem_op;
  assign w_wb_valid   = !rst && (w_alu_retire || (r_state == MS_DONE));
  assign w_wdata_mux  = mem_res_from_dram ? r_rdata : mem_alu_result;

  assign w_wb.valid = w_wb_valid;
  assign w_wb.rf_we = w_wb_valid && mem_ref_we && (mem_rd != '0);
  assign w_wb.rd    = w_wb_valid ? mem_rd : '0;
  assign w_wb.pc    = w_wb_valid ? mem_pc : '0;

  assign ms_to_ws_valid = w_wb.valid;
  assign ms_ready_go    = w_wb.valid && ws_allowin;
  assign ws_rf_we       = w_wb.rf_we;
  assign ws_rd          = w_wb.rd;
  assign ws_pc          = w_wb.pc;
  assign ws_wdata       = w_wb_valid ? w_wdata_mux : '0;

  assign data_sram_req   = !rst && (r_state == MS_REQ);
  assign data_sram_wr    = data_sram_req && mem_dram_we;
  assign data_sram_addr  = data_sram_req ? mem_dram_waddr : '0;
  assign data_sram_wdata = data_sram_req ? mem_dram_wdata : '0;

  generate
    if (TIMEOUT_CYC != 0) begin : g_wdog
      mem_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
      ) u_wdog (
        .clk   (clk),
        .rst   (rst),
        .i_wait(r_state == MS_WAIT),
        .o_err (w_err)
      );
    end else begin : g_no_wdog
      assign w_err = 1'b0;
    end
  endgenerate

  assign mem_err = !rst && w_err;

`ifdef MS_FWD_EN
  // Load data is not forwardable until the response has been captured.
  assign ms_fwd_valid = !rst && ms_valid && mem_ref_we && (mem_rd != '0);
  assign ms_fwd_rd    = ms_fwd_valid ? mem_rd : '0;
  assign ms_fwd_data  = w_wdata_mux;
  assign ms_fwd_block = !rst && ms_valid && mem_dram_re && (r_state != MS_DONE);
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: expected WB bundles are queued at issue and compared
// when the DUT retires (ms_ready_go), plus per-cycle handshake checks.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ms_valid;
  logic [31:0] mem_alu_result;
  logic        mem_ref_we;
  logic        mem_dram_re;
  logic        mem_dram_we;
  logic [4:0]  mem_rd;
  logic        mem_res_from_dram;
  logic [31:0] mem_dram_waddr;
  logic [31:0] mem_dram_wdata;
  logic [31:0] mem_pc;
  logic        ms_ready_go;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic        ws_rf_we;
  logic [4:0]  ws_rd;
  logic [31:0] ws_wdata;
  logic [31:0] ws_pc;
  logic        mem_err;

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .DATA_W     (32),
    .ADDR_W     (32),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ms_valid         (ms_valid),
    .mem_alu_result   (mem_alu_result),
    .mem_ref_we       (mem_ref_we),
    .mem_dram_re      (mem_dram_re),
    .mem_dram_we      (mem_dram_we),
    .mem_rd           (mem_rd),
    .mem_res_from_dram(mem_res_from_dram),
    .mem_dram_waddr   (mem_dram_waddr),
    .mem_dram_wdata   (mem_dram_wdata),
    .mem_pc           (mem_pc),
    .ms_ready_go      (ms_ready_go),
    .data_sram_req    (data_sram_req),
    .data_sram_wr     (data_sram_wr),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata  (data_sram_rdata),
    .ws_allowin       (ws_allowin),
    .ms_to_ws_valid   (ms_to_ws_valid),
    .ws_rf_we         (ws_rf_we),
    .ws_rd            (ws_rd),
    .ws_wdata         (ws_wdata),
    .ws_pc            (ws_pc),
    .mem_err          (mem_err)
  );

  typedef struct {
    logic [31:0] wdata;
    logic        rf_we;
    logic [4:0]  rd;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_instr(input logic v, input logic re, input logic we, input logic ref_we,
                           input logic from_dram, input logic [4:0] rd, input logic [31:0] alu,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc);
    ms_valid          = v;
    mem_dram_re       = re;
    mem_dram_we       = we;
    mem_ref_we        = ref_we;
    mem_res_from_dram = from_dram;
    mem_rd            = rd;
    mem_alu_result    = alu;
    mem_dram_waddr    = addr;
    mem_dram_wdata    = wd;
    mem_pc            = pc;
  endtask

  task automatic push_exp(input logic [31:0] wdata, input logic rf_we, input logic [4:0] rd,
                          input logic [31:0] pc);
    exp_t e;
    e.wdata = wdata;
    e.rf_we = rf_we;
    e.rd    = rd;
    e.pc    = pc;
    sb_q.push_back(e);
  endtask

  // Scoreboard side: every retirement must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ms_ready_go) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      end else begin
        sb_e = sb_q.pop_front();
        $display("retire pc=0x%08h rd=%0d rf_we=%0d wdata=0x%08h", ws_pc, ws_rd, ws_rf_we, ws_wdata);
        check_eq("wb_valid", 32'(ms_to_ws_valid), 32'd1);
        check_eq("wb_wdata", ws_wdata, sb_e.wdata);
        check_eq("wb_rf_we", 32'(ws_rf_we), 32'(sb_e.rf_we));
        check_eq("wb_rd", 32'(ws_rd), 32'(sb_e.rd));
        check_eq("wb_pc", ws_pc, sb_e.pc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL tb_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst               = 1'b1;
    ws_allowin        = 1'b1;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    set_instr(1, 0, 0, 1, 0, 5'd5, 32'h1234, 0, 0, 32'hAAAA);

    // Reset: outputs gated even with a valid ALU op presented.
    nxt();
    smp();
    check_eq("rst_valid", 32'(ms_to_ws_valid), 0);
    check_eq("rst_ready_go", 32'(ms_ready_go), 0);
    check_eq("rst_req", 32'(data_sram_req), 0);
    check_eq("rst_err", 32'(mem_err), 0);
    check_eq("rst_wdata", ws_wdata, 0);
    nxt();
    rst      = 1'b0;
    ms_valid = 1'b0;
    smp();
    check_eq("idle_valid", 32'(ms_to_ws_valid), 0);
    check_eq("idle_req", 32'(data_sram_req), 0);
    nxt();

    // ALU op retires in the same cycle.
    set_instr(1, 0, 0, 1, 0, 5'd5, 32'h1234, 0, 0, 32'h1000);
    push_exp(32'h1234, 1, 5'd5, 32'h1000);
    smp();
    check_eq("alu_valid", 32'(ms_to_ws_valid), 1);
    check_eq("alu_wdata", ws_wdata, 32'h1234);
    check_eq("alu_ready_go", 32'(ms_ready_go), 1);
    check_eq("alu_req", 32'(data_sram_req), 0);
    nxt();
    ms_valid = 1'b0;

    // Load: addr_ok on the third REQ cycle, data_ok three cycles later.
    set_instr(1, 1, 0, 1, 1, 5'd7, 32'h100, 32'h100, 0, 32'h1004);
    push_exp(32'hDEADBEEF, 1, 5'd7, 32'h1004);
    smp();
    check_eq("ld_idle_go", 32'(ms_ready_go), 0);
    nxt();
    for (int i = 0; i < 3; i++) begin
      data_sram_addr_ok = (i == 2);
      smp();
      check_eq("ld_req", 32'(data_sram_req), 1);
      check_eq("ld_addr", data_sram_addr, 32'h100);
      check_eq("ld_wr", 32'(data_sram_wr), 0);
      check_eq("ld_req_go", 32'(ms_ready_go), 0);
      nxt();
    end
    data_sram_addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_sram_data_ok = (i == 2);
      data_sram_rdata   = (i == 2) ? 32'hDEADBEEF : 32'h0;
      smp();
      check_eq("ld_wait_req", 32'(data_sram_req), 0);
      check_eq("ld_wait_go", 32'(ms_ready_go), 0);
      nxt();
    end
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    smp();
    check_eq("ld_done_go", 32'(ms_ready_go), 1);
    check_eq("ld_done_wdata", ws_wdata, 32'hDEADBEEF);
    nxt();
    ms_valid = 1'b0;

    // Load accepted and answered in one cycle, WB back-pressured for 4 cycles.
    set_instr(1, 1, 0, 1, 1, 5'd3, 32'h104, 32'h104, 0, 32'h1008);
    ws_allowin = 1'b0;
    push_exp(32'hCAFEF00D, 1, 5'd3, 32'h1008);
    smp();
    nxt();
    data_sram_addr_ok = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFEF00D;
    smp();
    check_eq("sc_req", 32'(data_sram_req), 1);
    nxt();
    data_sram_addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_sram_data_ok = (i == 1);
      data_sram_rdata   = (i == 1) ? 32'hBADBAD00 : 32'h0;
      smp();
      check_eq("sc_valid", 32'(ms_to_ws_valid), 1);
      check_eq("sc_wdata", ws_wdata, 32'hCAFEF00D);
      check_eq("sc_go", 32'(ms_ready_go), 0);
      nxt();
    end
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    ws_allowin        = 1'b1;
    smp();
    check_eq("sc_go_final", 32'(ms_ready_go), 1);
    nxt();
    ms_valid = 1'b0;

    // Store: request carries wr/addr/wdata, retires after the ack.
    set_instr(1, 0, 1, 0, 0, 5'd9, 32'h200, 32'h200, 32'h55, 32'h100C);
    push_exp(32'h200, 0, 5'd9, 32'h100C);
    smp();
    nxt();
    data_sram_addr_ok = 1'b1;
    smp();
    check_eq("st_req", 32'(data_sram_req), 1);
    check_eq("st_wr", 32'(data_sram_wr), 1);
    check_eq("st_addr", data_sram_addr, 32'h200);
    check_eq("st_wdata", data_sram_wdata, 32'h55);
    nxt();
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h12345678;
    smp();
    check_eq("st_wait_go", 32'(ms_ready_go), 0);
    nxt();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    smp();
    check_eq("st_done_go", 32'(ms_ready_go), 1);
    check_eq("st_rf_we", 32'(ws_rf_we), 0);
    nxt();
    ms_valid = 1'b0;

    // rd=0 suppresses the write; spurious data_ok in IDLE leaves state and buffer alone.
    set_instr(1, 0, 0, 1, 0, 5'd0, 32'h77, 0, 0, 32'h1010);
    push_exp(32'h77, 0, 5'd0, 32'h1010);
    smp();
    check_eq("r0_rf_we", 32'(ws_rf_we), 0);
    nxt();
    ms_valid          = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h999;
    smp();
    check_eq("spur_valid", 32'(ms_to_ws_valid), 0);
    check_eq("spur_req", 32'(data_sram_req), 0);
    nxt();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    set_instr(1, 0, 0, 1, 1, 5'd4, 32'h88, 0, 0, 32'h1014);
    push_exp(32'hCAFEF00D, 1, 5'd4, 32'h1014);
    smp();
    check_eq("spur_go", 32'(ms_ready_go), 1);
    nxt();
    ms_valid = 1'b0;

    // Watchdog: no data_ok, error after 8 WAIT cycles and sticky.
    set_instr(1, 1, 0, 1, 1, 5'd2, 32'h300, 32'h300, 0, 32'h1018);
    smp();
    nxt();
    data_sram_addr_ok = 1'b1;
    smp();
    nxt();
    data_sram_addr_ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      smp();
      check_eq("to_err_pre", 32'(mem_err), 0);
      check_eq("to_go", 32'(ms_ready_go), 0);
      nxt();
    end
    for (int i = 0; i < 3; i++) begin
      smp();
      check_eq("to_err_set", 32'(mem_err), 1);
      check_eq("to_req", 32'(data_sram_req), 0);
      nxt();
    end

    // Reset mid-WAIT, then a late data_ok that must be ignored.
    rst      = 1'b1;
    ms_valid = 1'b0;
    smp();
    check_eq("mid_rst_err", 32'(mem_err), 0);
    nxt();
    rst               = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBEEF;
    smp();
    check_eq("late_valid", 32'(ms_to_ws_valid), 0);
    check_eq("late_err", 32'(mem_err), 0);
    nxt();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    smp();
    check_eq("late_req", 32'(data_sram_req), 0);
    check_eq("late_err2", 32'(mem_err), 0);
    nxt();
    set_instr(1, 0, 0, 1, 1, 5'd6, 32'h99, 0, 0, 32'h101C);
    push_exp(32'h0, 1, 5'd6, 32'h101C);
    smp();
    check_eq("post_rst_go", 32'(ms_ready_go), 1);
    nxt();
    ms_valid = 1'b0;
    smp();
    check_eq("sb_empty", 32'(sb_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
